// File: rtl/csi2_rx_pkg.sv
// Shared types and defaults for the CSI-2 receive lane path.
package csi2_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    ACTIVE = 2'd2,
    RESYNC = 2'd3
  } lane_sync_state_t;

  localparam int DEFAULT_LANES = 4;

endpackage : csi2_rx_pkg

// File: rtl/csi2_lane_arrival.sv
// Per-lane sync tracker: sticky "seen" flag plus the skew count captured
// on the cycle the lane first reported a valid byte.
module csi2_lane_arrival
  import csi2_rx_pkg::*;
#(
  parameter int SKEW_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [SKEW_W-1:0] skew_i,
  output logic              seen_o,
  output logic [SKEW_W-1:0] arrival_o
);

  logic              seen_q, seen_d;
  logic [SKEW_W-1:0] arrival_q, arrival_d;

  // First valid sets seen and latches the arrival time; clear wins over capture.
  always_comb begin
    seen_d    = seen_q;
    arrival_d = arrival_q;
    if (clear_i) begin
      seen_d    = 1'b0;
      arrival_d = '0;
    end else if (valid_i && !seen_q) begin
      seen_d    = 1'b1;
      arrival_d = skew_i;
    end
  end

  // Seen / arrival registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seen_q    <= 1'b0;
      arrival_q <= '0;
    end else begin
      seen_q    <= seen_d;
      arrival_q <= arrival_d;
    end
  end

  assign seen_o    = seen_q;
  assign arrival_o = arrival_q;

endmodule : csi2_lane_arrival

// File: rtl/csi2_lane_sync_ctrl.sv
// Sequences the per-lane byte aligners of a multi-lane CSI-2 receiver:
// arms them for an HS burst, measures sync arrival skew, programs deskew
// delays and flags timeout / skew / lost-sync errors.
// Interface semantics: lane_valid_i is a level per lane (aligner locked and
// producing bytes); there is no backpressure. pkt_done_i, sync_err_o and
// skew_err_o are single-cycle pulses. All outputs come straight from flops.
module csi2_lane_sync_ctrl
  import csi2_rx_pkg::*;
#(
  parameter int  LANES    = DEFAULT_LANES,
  parameter int  MAX_SKEW = 3,
  parameter int  TIMEOUT  = 1024,
  localparam int SKEW_W   = $clog2(MAX_SKEW + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    hs_active_i,
  input  logic [LANES-1:0]        lane_valid_i,
  input  logic                    pkt_done_i,
  output logic [LANES-1:0]        reset_align_o,
  output logic [LANES*SKEW_W-1:0] lane_delay_o,
  output logic                    aligned_o,
  output logic                    sync_err_o,
  output logic                    skew_err_o
);

  localparam int                TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(MAX_SKEW);

  lane_sync_state_t          state_q, state_d;
  logic [TMO_W-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [SKEW_W-1:0]         skew_cnt_q, skew_cnt_d;
  logic [LANES*SKEW_W-1:0]   lane_delay_q, lane_delay_d;
  logic [LANES-1:0]          reset_align_q, reset_align_d;
  logic                      aligned_q, aligned_d;
  logic                      sync_err_q, sync_err_d;
  logic                      skew_err_q, skew_err_d;

  logic [LANES-1:0]          seen;
  logic [SKEW_W-1:0]         arrival [LANES];
  logic [LANES-1:0]          hunt_valid;
  logic [LANES-1:0]          seen_now;
  logic [SKEW_W-1:0]         skew_now;
  logic [SKEW_W-1:0]         skew_inc;
  logic [LANES*SKEW_W-1:0]   delay_now;

  // Only valids observed during HUNT count as sync arrivals.
  assign hunt_valid = lane_valid_i & {LANES{state_q == HUNT}};
  assign seen_now   = seen | hunt_valid;
  // Skew time is zero on the first seen cycle, then counts up from there.
  assign skew_now   = (|seen) ? skew_cnt_q : '0;
  assign skew_inc   = (skew_now == SKEW_MAX) ? SKEW_MAX : skew_now + 1'b1;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    csi2_lane_arrival #(.SKEW_W(SKEW_W)) u_arrival (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clear_i   (state_q == IDLE),
      .valid_i   (hunt_valid[g]),
      .skew_i    (skew_now),
      .seen_o    (seen[g]),
      .arrival_o (arrival[g])
    );
  end

  // Delay per lane: time from its arrival to now, so the latest lane gets 0.
  always_comb begin
    delay_now = '0;
    for (int i = 0; i < LANES; i++) begin
      delay_now[i*SKEW_W +: SKEW_W] = skew_now - (seen[i] ? arrival[i] : skew_now);
    end
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    skew_cnt_d   = skew_cnt_q;
    lane_delay_d = lane_delay_q;
    sync_err_d   = 1'b0;
    skew_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_cnt_d  = '0;
        skew_cnt_d = '0;
        if (hs_active_i) state_d = HUNT;
      end
      HUNT: begin
        if (tmo_cnt_q != TMO_LAST) tmo_cnt_d = tmo_cnt_q + 1'b1;
        skew_cnt_d = (|seen_now) ? skew_inc : '0;
        if (!hs_active_i) begin
          state_d = RESYNC;
        end else if (&seen_now) begin
          // Completing alignment beats a coincident skew limit or timeout.
          state_d      = ACTIVE;
          lane_delay_d = delay_now;
        end else if ((|seen_now) && (skew_now == SKEW_MAX)) begin
          skew_err_d = 1'b1;
          state_d    = RESYNC;
        end else if (!(|seen_now) && (tmo_cnt_q == TMO_LAST)) begin
          sync_err_d = 1'b1;
          state_d    = RESYNC;
        end
      end
      ACTIVE: begin
        if (pkt_done_i || !hs_active_i) begin
          state_d = RESYNC;
        end else if (!(&lane_valid_i)) begin
          sync_err_d = 1'b1;
          state_d    = RESYNC;
        end
      end
      RESYNC: begin
        // Wait out the rest of the burst; no re-hunt inside it.
        if (!hs_active_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) lane_delay_d = '0;
    reset_align_d = ((state_d == HUNT) || (state_d == ACTIVE)) ? '0 : '1;
    aligned_d     = (state_d == ACTIVE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      skew_cnt_q    <= '0;
      lane_delay_q  <= '0;
      reset_align_q <= '1;
      aligned_q     <= 1'b0;
      sync_err_q    <= 1'b0;
      skew_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      skew_cnt_q    <= skew_cnt_d;
      lane_delay_q  <= lane_delay_d;
      reset_align_q <= reset_align_d;
      aligned_q     <= aligned_d;
      sync_err_q    <= sync_err_d;
      skew_err_q    <= skew_err_d;
    end
  end

  assign reset_align_o = reset_align_q;
  assign lane_delay_o  = lane_delay_q;
  assign aligned_o     = aligned_q;
  assign sync_err_o    = sync_err_q;
  assign skew_err_o    = skew_err_q;

endmodule : csi2_lane_sync_ctrl

// File: tb/tb_csi2_lane_sync_ctrl.sv
// Bench for csi2_lane_sync_ctrl with default parameters (4 lanes,
// MAX_SKEW 3, TIMEOUT 1024). Expected outputs are queued as each cycle's
// stimulus is driven and compared one cycle later.
module tb_csi2_lane_sync_ctrl;
  import csi2_rx_pkg::*;

  localparam int LANES  = 4;
  localparam int SKEW_W = 2;
  localparam int EXP_W  = LANES + LANES * SKEW_W + 3;

  logic                    clk   = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    hs    = 1'b0;
  logic [LANES-1:0]        valid = '0;
  logic                    pkt   = 1'b0;
  logic [LANES-1:0]        reset_align;
  logic [LANES*SKEW_W-1:0] lane_delay;
  logic                    aligned;
  logic                    sync_err;
  logic                    skew_err;

  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Clock.
  always #5 clk = ~clk;

  csi2_lane_sync_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .hs_active_i   (hs),
    .lane_valid_i  (valid),
    .pkt_done_i    (pkt),
    .reset_align_o (reset_align),
    .lane_delay_o  (lane_delay),
    .aligned_o     (aligned),
    .sync_err_o    (sync_err),
    .skew_err_o    (skew_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk(input logic [3:0] ra, input logic [7:0] dly,
                                          input logic al, input logic se, input logic ke);
    return {ra, dly, al, se, ke};
  endfunction

  // Drive one cycle of inputs, queue its expected outputs, compare after the edge.
  task automatic drive(input string tag, input logic h, input logic [3:0] v,
                       input logic p, input logic [EXP_W-1:0] e);
    logic [EXP_W-1:0] x;
    hs    = h;
    valid = v;
    pkt   = p;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check_val({tag, ".reset_align"}, 32'(reset_align), 32'(x[14:11]));
    check_val({tag, ".lane_delay"},  32'(lane_delay),  32'(x[10:3]));
    check_val({tag, ".aligned"},     32'(aligned),     32'(x[2]));
    check_val({tag, ".sync_err"},    32'(sync_err),    32'(x[1]));
    check_val({tag, ".skew_err"},    32'(skew_err),    32'(x[0]));
  endtask

  task automatic check_state(input string tag, input lane_sync_state_t st);
    check_val({tag, ".state"}, 32'(dut.state_q), 32'(st));
  endtask

  initial begin
    // Reset block.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.reset_align", 32'(reset_align), 32'hF);
    check_val("rst.lane_delay",  32'(lane_delay),  32'h0);
    check_val("rst.aligned",     32'(aligned),     32'h0);
    check_val("rst.errs",        32'({sync_err, skew_err}), 32'h0);
    check_state("rst", IDLE);
    rst_n = 1'b1;
    drive("idle", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Scenario 1: all lanes together, 5 cycles after hs rises.
    drive("s1.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 4; i++) drive("s1.hunt", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s1.sync", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h00, 1, 0, 0));
    check_state("s1.sync", ACTIVE);
    for (int i = 0; i < 3; i++) drive("s1.act", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h00, 1, 0, 0));
    drive("s1.pkt", 1'b1, 4'hF, 1'b1, mk(4'hF, 8'h00, 0, 0, 0));
    drive("s1.rsy", 1'b1, 4'hF, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    drive("s1.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Scenario 2: staggered arrival, then lane 1 drops in ACTIVE.
    drive("s2.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s2.t0", 1'b1, 4'b0011, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s2.t1", 1'b1, 4'b0111, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s2.t2", 1'b1, 4'b0111, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s2.t3", 1'b1, 4'b1111, 1'b0, mk(4'h0, 8'h2F, 1, 0, 0));
    for (int i = 0; i < 2; i++) drive("s2.act", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h2F, 1, 0, 0));
    drive("s2.drop", 1'b1, 4'b1101, 1'b0, mk(4'hF, 8'h2F, 0, 1, 0));
    drive("s2.rsy", 1'b1, 4'hF, 1'b0, mk(4'hF, 8'h2F, 0, 0, 0));
    drive("s2.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Scenario 5b: packet end coinciding with a valid drop raises no error.
    drive("s5.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s5.sync", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h00, 1, 0, 0));
    drive("s5.pkdrop", 1'b1, 4'b1101, 1'b1, mk(4'hF, 8'h00, 0, 0, 0));
    drive("s5.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Scenario 3: lane 3 never syncs -> skew error at the skew limit.
    drive("s3.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s3.t0", 1'b1, 4'b0111, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s3.t1", 1'b1, 4'b0111, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s3.t2", 1'b1, 4'b0111, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s3.t3", 1'b1, 4'b0111, 1'b0, mk(4'hF, 8'h00, 0, 0, 1));
    for (int i = 0; i < 3; i++) drive("s3.rsy", 1'b1, 4'hF, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    check_state("s3.rsy", RESYNC);
    drive("s3.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    check_state("s3.end", IDLE);

    // Scenario 4: no lane ever syncs -> timeout on the 1024th hunt cycle.
    drive("s4.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) drive("s4.tmo", 1'b1, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 1, 0));
      else           drive("s4.hunt", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    end
    check_state("s4.tmo", RESYNC);
    drive("s4.rsy", 1'b1, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    drive("s4.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Scenario 6: async reset in ACTIVE, then a fresh burst realigns.
    drive("s6.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s6.t0", 1'b1, 4'b1000, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s6.t1", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h40, 1, 0, 0));
    drive("s6.act", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h40, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check_val("s6.rst.reset_align", 32'(reset_align), 32'hF);
    check_val("s6.rst.lane_delay",  32'(lane_delay),  32'h0);
    check_val("s6.rst.aligned",     32'(aligned),     32'h0);
    check_state("s6.rst", IDLE);
    hs = 1'b0;
    valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive("s6.idle", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    drive("s6.rise2", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s6.u0", 1'b1, 4'b0100, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s6.u1", 1'b1, 4'b0100, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
    drive("s6.u2", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h20, 1, 0, 0));
    drive("s6.hsoff", 1'b0, 4'hF, 1'b0, mk(4'hF, 8'h20, 0, 0, 0));
    drive("s6.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));

    // Random-length hunt delay before a simultaneous sync.
    for (int r = 0; r < 4; r++) begin
      int unsigned wait_n;
      wait_n = $urandom_range(0, 20);
      drive("rnd.rise", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
      for (int i = 0; i < int'(wait_n); i++)
        drive("rnd.hunt", 1'b1, 4'h0, 1'b0, mk(4'h0, 8'h00, 0, 0, 0));
      drive("rnd.sync", 1'b1, 4'hF, 1'b0, mk(4'h0, 8'h00, 1, 0, 0));
      drive("rnd.pkt", 1'b1, 4'hF, 1'b1, mk(4'hF, 8'h00, 0, 0, 0));
      drive("rnd.end", 1'b0, 4'h0, 1'b0, mk(4'hF, 8'h00, 0, 0, 0));
    end

    // Report.
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_csi2_lane_sync_ctrl
